nts_mac_rx_collector: RTL and testbench

- Receive-side counterpart of the NTS TX extractor.
- Accepts 64-bit MAC RX words with per-byte valid flags and byte-reverses them into NTS word order.
- Writes each frame into one of 4 internal frame buffers, selected round-robin, then flags that buffer ready with its length and last-word byte count.
- Downstream parser engines read buffers through a shared read port and release them when done.

---
 rtl/nts_rx_pkg.sv | 41 ++++
 rtl/nts_rx_buffer_mem.sv | 32 +++
 rtl/nts_mac_rx_collector.sv | 245 ++++++++++++++++++++++++
 tb/tb_nts_mac_rx_collector.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/nts_rx_pkg.sv
// nts_rx_pkg: shared definitions for the NTS MAC RX collector.
//   BUFFERS / BSELADDR : frame buffer count and buffer-select width
//   rx_state_t         : receive FSM state encoding
//   byte_reverse()     : MAC byte order -> NTS word order, invalid bytes zeroed
//   dv_to_lwdv()       : valid-byte flags -> last-word valid byte count
package nts_rx_pkg;

    localparam int BUFFERS  = 4;
    localparam int BSELADDR = 2;

    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_RECEIVE = 2'd1,
        RX_DROP    = 2'd2
    } rx_state_t;

    // The MAC delivers the first byte in bits [7:0]; NTS words carry the first
    // byte in bits [63:56]. Bytes not flagged valid are forced to zero so the
    // tail of a short last word is deterministic for the parsers.
    function automatic logic [63:0] byte_reverse(input logic [63:0] data,
                                                 input logic [7:0]  dv);
        logic [63:0] rev;
        rev = '0;
        for (int i = 0; i < 8; i++) begin
            if (dv[i]) begin
                rev[(7 - i) * 8 +: 8] = data[i * 8 +: 8];
            end
        end
        return rev;
    endfunction

    function automatic logic [3:0] dv_to_lwdv(input logic [7:0] dv);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, dv[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/nts_rx_buffer_mem.sv
// nts_rx_buffer_mem: one simple dual-port 64-bit frame buffer.
//   i_clk      : clock
//   i_wr_en    : write strobe
//   i_wr_addr  : write word address
//   i_wr_data  : write data (already in NTS byte order)
//   i_rd_addr  : read word address
//   o_rd_data  : registered read data, 1-cycle latency
// Contents are never reset so the array maps onto block RAM.
module nts_rx_buffer_mem #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [63:0]           i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [63:0]           o_rd_data
);

    logic [63:0] mem [0:(1 << ADDR_WIDTH)-1];
    logic [63:0] rd_data_reg;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
        rd_data_reg <= mem[i_rd_addr];
    end

    assign o_rd_data = rd_data_reg;

endmodule

// File: rtl/nts_mac_rx_collector.sv
// nts_mac_rx_collector: collects MAC RX frames into 4 round-robin buffers.
//   i_clk, i_areset_n      : clock, asynchronous active-low reset
//   i_mac_rx_data_valid    : per-byte valid, contiguous from bit 0
//   i_mac_rx_data          : MAC word, first byte in [7:0]
//   i_mac_rx_good_frame    : end-of-frame pulse, frame OK
//   i_mac_rx_bad_frame     : end-of-frame pulse, frame corrupt
//   o_buffer_ready         : bit n set while buffer n holds a committed frame
//   i_buffer_release       : bit n pulse frees buffer n
//   o_buffer_length        : per-buffer word count, [n*ADDR_WIDTH +: ADDR_WIDTH]
//   o_buffer_lwdv          : per-buffer last-word valid byte count, [4n +: 4]
//   i_rd_buffer, i_rd_addr : shared read port select/address
//   o_rd_data              : read data (NTS byte order), 1-cycle latency
// Optional macro NTS_RX_STATS_EN adds saturating 32-bit counters
//   o_stat_good, o_stat_bad, o_stat_dropped.
module nts_mac_rx_collector
    import nts_rx_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                          i_clk,
    input  logic                          i_areset_n,
    input  logic [7:0]                    i_mac_rx_data_valid,
    input  logic [63:0]                   i_mac_rx_data,
    input  logic                          i_mac_rx_good_frame,
    input  logic                          i_mac_rx_bad_frame,
    output logic [BUFFERS-1:0]            o_buffer_ready,
    input  logic [BUFFERS-1:0]            i_buffer_release,
    output logic [BUFFERS*ADDR_WIDTH-1:0] o_buffer_length,
    output logic [BUFFERS*4-1:0]          o_buffer_lwdv,
    input  logic [BSELADDR-1:0]           i_rd_buffer,
    input  logic [ADDR_WIDTH-1:0]         i_rd_addr,
    output logic [63:0]                   o_rd_data
`ifdef NTS_RX_STATS_EN
    ,
    output logic [31:0]                   o_stat_good,
    output logic [31:0]                   o_stat_bad,
    output logic [31:0]                   o_stat_dropped
`endif
);

    rx_state_t               state_reg, state_next;
    logic [BSELADDR-1:0]     sel_ptr_reg, sel_ptr_next;
    logic [ADDR_WIDTH-1:0]   wr_addr_reg, wr_addr_next;
    logic [7:0]              last_dv_reg, last_dv_next;
    logic [BUFFERS-1:0]      ready_reg, ready_next;

    logic                    has_data;
    logic                    end_pulse;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr_mem;
    logic [63:0]             wr_data;
    logic                    commit;
    logic [ADDR_WIDTH-1:0]   commit_len;
    logic [7:0]              commit_dv;
    logic                    drop_evt;
    logic                    bad_evt;

    logic [BUFFERS-1:0][63:0] mem_rd_data;
    logic [BSELADDR-1:0]     rd_buffer_reg;
    logic                    rd_valid_reg;

    assign has_data  = |i_mac_rx_data_valid;
    assign end_pulse = i_mac_rx_good_frame | i_mac_rx_bad_frame;
    assign wr_data   = byte_reverse(i_mac_rx_data, i_mac_rx_data_valid);

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_reg   <= RX_IDLE;
            sel_ptr_reg <= '0;
            wr_addr_reg <= '0;
            last_dv_reg <= '0;
            ready_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            sel_ptr_reg <= sel_ptr_next;
            wr_addr_reg <= wr_addr_next;
            last_dv_reg <= last_dv_next;
            ready_reg   <= ready_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        sel_ptr_next = sel_ptr_reg;
        wr_addr_next = wr_addr_reg;
        last_dv_next = last_dv_reg;
        wr_en        = 1'b0;
        wr_addr_mem  = wr_addr_reg;
        commit       = 1'b0;
        commit_len   = wr_addr_reg;
        commit_dv    = last_dv_reg;
        drop_evt     = 1'b0;
        bad_evt      = 1'b0;

        case (state_reg)
            RX_IDLE: begin
                if (has_data) begin
                    if (!ready_reg[sel_ptr_reg]) begin
                        wr_en       = 1'b1;
                        wr_addr_mem = '0;
                        if (i_mac_rx_good_frame) begin
                            // single-word frame, committed immediately
                            commit     = 1'b1;
                            commit_len = ADDR_WIDTH'(1);
                            commit_dv  = i_mac_rx_data_valid;
                        end else if (i_mac_rx_bad_frame) begin
                            bad_evt = 1'b1;
                        end else begin
                            state_next   = RX_RECEIVE;
                            wr_addr_next = ADDR_WIDTH'(1);
                            last_dv_next = i_mac_rx_data_valid;
                        end
                    end else begin
                        drop_evt = 1'b1;
                        if (!end_pulse) begin
                            state_next = RX_DROP;
                        end
                    end
                end
            end

            RX_RECEIVE: begin
                // wr_addr is at least 1 on entry, so 0 here means it wrapped
                if (has_data && (wr_addr_reg == '0)) begin
                    drop_evt   = 1'b1;
                    state_next = end_pulse ? RX_IDLE : RX_DROP;
                end else if (i_mac_rx_good_frame) begin
                    commit     = 1'b1;
                    state_next = RX_IDLE;
                    if (has_data) begin
                        wr_en      = 1'b1;
                        commit_len = wr_addr_reg + 1'b1;
                        commit_dv  = i_mac_rx_data_valid;
                    end
                end else if (i_mac_rx_bad_frame) begin
                    bad_evt    = 1'b1;
                    state_next = RX_IDLE;
                end else if (has_data) begin
                    wr_en        = 1'b1;
                    wr_addr_next = wr_addr_reg + 1'b1;
                    last_dv_next = i_mac_rx_data_valid;
                end
            end

            RX_DROP: begin
                if (end_pulse) begin
                    state_next = RX_IDLE;
                end
            end

            default: state_next = RX_IDLE;
        endcase

        if (commit) begin
            sel_ptr_next = sel_ptr_reg + 1'b1;
        end
    end

    // Commit only ever targets a free buffer, so it cannot collide with a
    // release of the same buffer.
    always_comb begin
        ready_next = ready_reg & ~i_buffer_release;
        if (commit) begin
            ready_next[sel_ptr_reg] = 1'b1;
        end
    end

    assign o_buffer_ready = ready_reg;

    genvar gi;
    generate
        for (gi = 0; gi < BUFFERS; gi++) begin : g_buf
            logic [ADDR_WIDTH-1:0] length_reg;
            logic [3:0]            lwdv_reg;
            logic                  sel_hit;

            assign sel_hit = (sel_ptr_reg == BSELADDR'(gi));

            always_ff @(posedge i_clk or negedge i_areset_n) begin
                if (!i_areset_n) begin
                    length_reg <= '0;
                    lwdv_reg   <= '0;
                end else if (commit && sel_hit) begin
                    length_reg <= commit_len;
                    lwdv_reg   <= dv_to_lwdv(commit_dv);
                end
            end

            assign o_buffer_length[gi*ADDR_WIDTH +: ADDR_WIDTH] = length_reg;
            assign o_buffer_lwdv[gi*4 +: 4]                     = lwdv_reg;

            nts_rx_buffer_mem #(
                .ADDR_WIDTH (ADDR_WIDTH)
            ) u_mem (
                .i_clk     (i_clk),
                .i_wr_en   (wr_en && sel_hit),
                .i_wr_addr (wr_addr_mem),
                .i_wr_data (wr_data),
                .i_rd_addr (i_rd_addr),
                .o_rd_data (mem_rd_data[gi])
            );
        end
    endgenerate

    // The RAM output registers are not reset; rd_valid_reg holds the read
    // port at zero until the first post-reset read has been captured.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            rd_buffer_reg <= '0;
            rd_valid_reg  <= 1'b0;
        end else begin
            rd_buffer_reg <= i_rd_buffer;
            rd_valid_reg  <= 1'b1;
        end
    end

    assign o_rd_data = rd_valid_reg ? mem_rd_data[rd_buffer_reg] : 64'd0;

`ifdef NTS_RX_STATS_EN
    logic [31:0] stat_good_reg, stat_bad_reg, stat_dropped_reg;

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            stat_good_reg    <= '0;
            stat_bad_reg     <= '0;
            stat_dropped_reg <= '0;
        end else begin
            if (commit && (stat_good_reg != '1)) begin
                stat_good_reg <= stat_good_reg + 32'd1;
            end
            if (bad_evt && (stat_bad_reg != '1)) begin
                stat_bad_reg <= stat_bad_reg + 32'd1;
            end
            if (drop_evt && (stat_dropped_reg != '1)) begin
                stat_dropped_reg <= stat_dropped_reg + 32'd1;
            end
        end
    end

    assign o_stat_good    = stat_good_reg;
    assign o_stat_bad     = stat_bad_reg;
    assign o_stat_dropped = stat_dropped_reg;
`endif

endmodule

// File: tb/tb_nts_mac_rx_collector.sv
module tb_nts_mac_rx_collector;

    localparam int AW = 4;

    logic           clk;
    logic           areset_n;
    logic [7:0]     rx_dv;
    logic [63:0]    rx_data;
    logic           rx_good;
    logic           rx_bad;
    logic [3:0]     buf_ready;
    logic [3:0]     buf_release;
    logic [4*AW-1:0] buf_length;
    logic [15:0]    buf_lwdv;
    logic [1:0]     rd_buffer;
    logic [AW-1:0]  rd_addr;
    logic [63:0]    rd_data;
`ifdef NTS_RX_STATS_EN
    logic [31:0]    stat_good, stat_bad, stat_dropped;
`endif

    nts_mac_rx_collector #(
        .ADDR_WIDTH (AW)
    ) dut (
        .i_clk               (clk),
        .i_areset_n          (areset_n),
        .i_mac_rx_data_valid (rx_dv),
        .i_mac_rx_data       (rx_data),
        .i_mac_rx_good_frame (rx_good),
        .i_mac_rx_bad_frame  (rx_bad),
        .o_buffer_ready      (buf_ready),
        .i_buffer_release    (buf_release),
        .o_buffer_length     (buf_length),
        .o_buffer_lwdv       (buf_lwdv),
        .i_rd_buffer         (rd_buffer),
        .i_rd_addr           (rd_addr),
        .o_rd_data           (rd_data)
`ifdef NTS_RX_STATS_EN
        ,
        .o_stat_good         (stat_good),
        .o_stat_bad          (stat_bad),
        .o_stat_dropped      (stat_dropped)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         n_words;
        logic [7:0] last_dv;
        bit         bad;
        bit         coinc;
        logic [3:0] rel_pre;
        logic [3:0] rel_end;
        logic [3:0] exp_ready;
        int         exp_buf;
        int         exp_len;
        int         exp_lwdv;
    } frame_vec_t;

    frame_vec_t  vecs [14];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] frame_words [32];
    logic [63:0] mem_model [4][16];
    logic [63:0] sb_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference byte reversal written from the MAC/NTS ordering rule
    function automatic logic [63:0] ref_rev(input logic [63:0] d, input logic [7:0] dv);
        logic [63:0] r;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            if (dv[b]) r[63 - 8*b -: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_release(input logic [3:0] mask);
        if (mask != 4'b0000) begin
            buf_release = mask;
            tick();
            buf_release = 4'b0000;
        end
    endtask

    task automatic send_frame(input int n, input logic [7:0] ldv, input bit bad,
                              input bit coinc, input logic [3:0] rel_end);
        for (int i = 0; i < n; i++) begin
            rx_dv   = (i == n - 1) ? ldv : 8'hFF;
            rx_data = {$urandom(), $urandom()};
            if (i < 32) frame_words[i] = ref_rev(rx_data, rx_dv);
            if (i == n - 1 && coinc) begin
                rx_good     = !bad;
                rx_bad      = bad;
                buf_release = rel_end;
            end
            tick();
        end
        rx_dv       = 8'h00;
        rx_data     = '0;
        rx_good     = 1'b0;
        rx_bad      = 1'b0;
        buf_release = 4'b0000;
        if (!coinc) begin
            tick();
            tick();
            rx_good     = !bad;
            rx_bad      = bad;
            buf_release = rel_end;
            tick();
            rx_good     = 1'b0;
            rx_bad      = 1'b0;
            buf_release = 4'b0000;
        end
    endtask

    task automatic read_back(input int b, input int n);
        for (int a = 0; a < n; a++) begin
            rd_buffer = 2'(b);
            rd_addr   = AW'(a);
            sb_q.push_back(mem_model[b][a]);
            tick();
            check($sformatf("rd_data b%0d a%0d", b, a), rd_data, sb_q.pop_front());
        end
    endtask

    task automatic check_commit(input string tag, input int b, input int len, input int lwdv);
        check({tag, " length"}, 64'(buf_length[b*AW +: AW]), 64'(len));
        check({tag, " lwdv"}, 64'(buf_lwdv[b*4 +: 4]), 64'(lwdv));
        for (int a = 0; a < len; a++) mem_model[b][a] = frame_words[a];
        read_back(b, len);
    endtask

    initial begin
        //        n   ldv    bad coin rel_pre  rel_end  ready    buf len lwdv
        vecs[0]  = '{3,  8'h0F, 0, 1, 4'b0000, 4'b0000, 4'b0001, 0, 3,  4};
        vecs[1]  = '{2,  8'hFF, 0, 0, 4'b0000, 4'b0000, 4'b0011, 1, 2,  8};
        vecs[2]  = '{1,  8'h01, 1, 1, 4'b0000, 4'b0000, 4'b0011, -1, 0, 0};
        vecs[3]  = '{1,  8'h01, 0, 1, 4'b0000, 4'b0000, 4'b0111, 2, 1,  1};
        vecs[4]  = '{4,  8'h07, 0, 0, 4'b0000, 4'b0000, 4'b1111, 3, 4,  3};
        vecs[5]  = '{2,  8'hFF, 0, 1, 4'b0000, 4'b0000, 4'b1111, -1, 0, 0};
        vecs[6]  = '{5,  8'h3F, 0, 1, 4'b0001, 4'b0000, 4'b1111, 0, 5,  6};
        vecs[7]  = '{17, 8'hFF, 0, 1, 4'b1111, 4'b0000, 4'b0000, -1, 0, 0};
        vecs[8]  = '{2,  8'h7F, 0, 0, 4'b0000, 4'b0000, 4'b0010, 1, 2,  7};
        vecs[9]  = '{15, 8'h03, 0, 1, 4'b0000, 4'b0000, 4'b0110, 2, 15, 2};
        vecs[10] = '{1,  8'h0F, 0, 0, 4'b0000, 4'b0000, 4'b1110, 3, 1,  4};
        vecs[11] = '{2,  8'hFF, 0, 1, 4'b1000, 4'b0010, 4'b0101, 0, 2,  8};
        vecs[12] = '{3,  8'h1F, 1, 0, 4'b1100, 4'b0000, 4'b0001, -1, 0, 0};
        vecs[13] = '{1,  8'hFF, 0, 1, 4'b0000, 4'b0000, 4'b0011, 1, 1,  8};

        areset_n    = 1'b0;
        rx_dv       = 8'h00;
        rx_data     = '0;
        rx_good     = 1'b0;
        rx_bad      = 1'b0;
        buf_release = 4'b0000;
        rd_buffer   = 2'd0;
        rd_addr     = '0;
        tick();
        tick();
        check("reset ready", 64'(buf_ready), 64'h0);
        check("reset length", 64'(buf_length), 64'h0);
        check("reset lwdv", 64'(buf_lwdv), 64'h0);
        check("reset rd_data", rd_data, 64'h0);
        areset_n = 1'b1;
        tick();

        for (int v = 0; v < 14; v++) begin
            pulse_release(vecs[v].rel_pre);
            send_frame(vecs[v].n_words, vecs[v].last_dv, vecs[v].bad,
                       vecs[v].coinc, vecs[v].rel_end);
            $display("frame %0d: words=%0d last_dv=%h bad=%0d ready=%b", v,
                     vecs[v].n_words, vecs[v].last_dv, vecs[v].bad, buf_ready);
            check($sformatf("frame %0d ready", v), 64'(buf_ready), 64'(vecs[v].exp_ready));
            if (vecs[v].exp_buf >= 0) begin
                check_commit($sformatf("frame %0d", v), vecs[v].exp_buf,
                             vecs[v].exp_len, vecs[v].exp_lwdv);
            end
        end

        // Reset in the middle of a frame, then the MAC's trailing good pulse
        pulse_release(4'b1111);
        rx_dv = 8'hFF;
        rx_data = {$urandom(), $urandom()};
        tick();
        rx_data = {$urandom(), $urandom()};
        tick();
        rx_dv    = 8'h00;
        areset_n = 1'b0;
        #2;
        areset_n = 1'b1;
        tick();
        rx_good = 1'b1;
        tick();
        rx_good = 1'b0;
        tick();
        $display("midframe reset: ready=%b", buf_ready);
        check("midreset ready", 64'(buf_ready), 64'h0);
        check("midreset length", 64'(buf_length), 64'h0);

        // Pointer must be back at buffer 0
        send_frame(1, 8'h03, 1'b0, 1'b1, 4'b0000);
        $display("post-reset frame: ready=%b", buf_ready);
        check("postreset ready", 64'(buf_ready), 64'h1);
        check_commit("postreset", 0, 1, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
